// File: rtl/ifu_mem_rsp_pkg.sv
// ifu_pkg: shared parameters, types and helpers for the IFU memory responder.
// No ports; imported by the interface, the tag FIFO and the responder top.
package ifu_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int LINE_WIDTH     = 64;
    localparam int WORD_WIDTH     = 32;
    localparam int OFFSET_WIDTH   = 3;
    localparam int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
    localparam int REQ_FIFO_DEPTH = 4;

    localparam int WORD_IDX_WIDTH = $clog2(WORDS_PER_LINE);
    localparam int BYTE_OFS_WIDTH = OFFSET_WIDTH - WORD_IDX_WIDTH;
    localparam int FIFO_PTR_WIDTH = $clog2(REQ_FIFO_DEPTH);

    localparam logic [WORD_IDX_WIDTH-1:0] LAST_WORD_IDX = WORD_IDX_WIDTH'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        RESP
    } t_mem_rsp_state;

    // Word-aligned ROM byte address of word idx within the line of tag.
    function automatic logic [ADDR_WIDTH-1:0] wordAddr(input logic [TAG_WIDTH-1:0]      tag,
                                                       input logic [WORD_IDX_WIDTH-1:0] idx);
        return {tag, idx, {BYTE_OFS_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/ifu_mem_rsp_if.sv
// ifu_mem_rsp_if: bundles the cache request/response port, the ROM read port
// and the responder status flags.
//   slave  : responder side (takes req_* and rom_rdDataIn, drives the rest)
//   master : cache/ROM side
interface ifu_mem_rsp_if;
    import ifu_pkg::*;

    logic [TAG_WIDTH-1:0]  req_tagIn;
    logic                  req_tagValidIn;
    logic                  req_readyOut;
    logic [TAG_WIDTH-1:0]  rsp_tagOut;
    logic [LINE_WIDTH-1:0] rsp_insLineOut;
    logic                  rsp_insLineValidOut;
    logic                  rom_rdEnOut;
    logic [ADDR_WIDTH-1:0] rom_rdAddrOut;
    logic [WORD_WIDTH-1:0] rom_rdDataIn;
    logic                  busyOut;
    logic                  overflowErrOut;

    modport slave (
        input  req_tagIn, req_tagValidIn, rom_rdDataIn,
        output req_readyOut, rsp_tagOut, rsp_insLineOut, rsp_insLineValidOut,
               rom_rdEnOut, rom_rdAddrOut, busyOut, overflowErrOut
    );

    modport master (
        output req_tagIn, req_tagValidIn, rom_rdDataIn,
        input  req_readyOut, rsp_tagOut, rsp_insLineOut, rsp_insLineValidOut,
               rom_rdEnOut, rom_rdAddrOut, busyOut, overflowErrOut
    );

endinterface

// File: rtl/ifu_mem_rsp_req_fifo.sv
// ifu_req_fifo: pending miss-tag queue.
//   Clock, Rst            : clock, synchronous active-low reset
//   pushIn, pushTagIn     : enqueue a tag (ignored when full)
//   popIn, headTagOut     : dequeue / current head tag (ignored when empty)
//   fullOut, emptyOut     : occupancy flags from registered pointers
//   matchTagIn, matchOut  : combinational "tag is already queued" lookup
module ifu_req_fifo
    import ifu_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Rst,
    input  logic                 pushIn,
    input  logic [TAG_WIDTH-1:0] pushTagIn,
    input  logic                 popIn,
    output logic [TAG_WIDTH-1:0] headTagOut,
    output logic                 fullOut,
    output logic                 emptyOut,
    input  logic [TAG_WIDTH-1:0] matchTagIn,
    output logic                 matchOut
);

    localparam int PTR_W = FIFO_PTR_WIDTH + 1;

    logic [TAG_WIDTH-1:0]      mem [REQ_FIFO_DEPTH];
    logic [PTR_W-1:0]          wrPtr, rdPtr, count;
    logic [FIFO_PTR_WIDTH-1:0] slot;

    // Extra pointer bit separates full (MSBs differ) from empty (equal).
    assign count      = wrPtr - rdPtr;
    assign emptyOut   = (wrPtr == rdPtr);
    assign fullOut    = (wrPtr[FIFO_PTR_WIDTH-1:0] == rdPtr[FIFO_PTR_WIDTH-1:0]) &&
                        (wrPtr[FIFO_PTR_WIDTH] != rdPtr[FIFO_PTR_WIDTH]);
    assign headTagOut = mem[rdPtr[FIFO_PTR_WIDTH-1:0]];

    // Only slots between rdPtr and wrPtr hold live tags.
    always_comb begin
        matchOut = 1'b0;
        slot     = '0;
        for (int i = 0; i < REQ_FIFO_DEPTH; i++) begin
            slot = rdPtr[FIFO_PTR_WIDTH-1:0] + FIFO_PTR_WIDTH'(i);
            if ((PTR_W'(i) < count) && (mem[slot] == matchTagIn)) begin
                matchOut = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (pushIn && !fullOut) begin
            mem[wrPtr[FIFO_PTR_WIDTH-1:0]] <= pushTagIn;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushIn && !fullOut) wrPtr <= wrPtr + 1'b1;
            if (popIn && !emptyOut) rdPtr <= rdPtr + 1'b1;
        end
    end

endmodule

// File: rtl/ifu_mem_rsp.sv
// ifu_mem_rsp: memory-side line-fill responder for the IFU cache. Queues miss
// tags, reads each line word-by-word from the instruction ROM, and returns the
// assembled line as a one-cycle response pulse.
//   Clock, Rst : clock, synchronous active-low reset
//   bus        : ifu_mem_rsp_if.slave (cache req/rsp, ROM read port, status)
//
// state | meaning
// IDLE  | nothing in flight; pop the next queued tag if any
// FETCH | one ROM read strobe per cycle, word 0 .. WORDS_PER_LINE-1
// DRAIN | last word arrives from the ROM; line registered out
// RESP  | response pulse; pop next tag straight into FETCH if queued
module ifu_mem_rsp
    import ifu_pkg::*;
(
    input  logic        Clock,
    input  logic        Rst,
    ifu_mem_rsp_if.slave bus
);

    t_mem_rsp_state            state;
    logic [TAG_WIDTH-1:0]      curTag;
    logic [WORD_IDX_WIDTH-1:0] issueIdx, capIdx, nextIdx;
    logic                      capValid;
    logic [LINE_WIDTH-1:0]     lineBuf, lineNext;
    logic                      romRdEn;
    logic [ADDR_WIDTH-1:0]     romRdAddr;
    logic [TAG_WIDTH-1:0]      rspTag;
    logic [LINE_WIDTH-1:0]     rspLine;
    logic                      rspValid;
    logic                      overflowErr;

    logic                      fifoFull, fifoEmpty, fifoMatch;
    logic [TAG_WIDTH-1:0]      fifoHead;
    logic                      isDup, push, pop;

    ifu_req_fifo u_reqFifo (
        .Clock      (Clock),
        .Rst        (Rst),
        .pushIn     (push),
        .pushTagIn  (bus.req_tagIn),
        .popIn      (pop),
        .headTagOut (fifoHead),
        .fullOut    (fifoFull),
        .emptyOut   (fifoEmpty),
        .matchTagIn (bus.req_tagIn),
        .matchOut   (fifoMatch)
    );

    // A cache holding its miss request re-presents the same tag every cycle;
    // the line being fetched (up to and including its RESP cycle) counts too.
    assign isDup   = fifoMatch || ((state != IDLE) && (bus.req_tagIn == curTag));
    assign push    = bus.req_tagValidIn && !fifoFull && !isDup;
    assign pop     = ((state == IDLE) || (state == RESP)) && !fifoEmpty;
    assign nextIdx = issueIdx + 1'b1;

    always_comb begin
        lineNext = lineBuf;
        if (capValid) begin
            lineNext[capIdx*WORD_WIDTH +: WORD_WIDTH] = bus.rom_rdDataIn;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state       <= IDLE;
            curTag      <= '0;
            issueIdx    <= '0;
            capIdx      <= '0;
            capValid    <= 1'b0;
            lineBuf     <= '0;
            romRdEn     <= 1'b0;
            romRdAddr   <= '0;
            rspTag      <= '0;
            rspLine     <= '0;
            rspValid    <= 1'b0;
            overflowErr <= 1'b0;
        end else begin
            romRdEn  <= 1'b0;
            rspValid <= 1'b0;
            // ROM data is valid exactly one cycle after each strobe.
            capValid <= romRdEn;
            if (capValid) begin
                lineBuf <= lineNext;
                capIdx  <= capIdx + 1'b1;
            end
            if (bus.req_tagValidIn && fifoFull && !isDup) begin
                overflowErr <= 1'b1;
            end
            case (state)
                IDLE, RESP: begin
                    if (pop) begin
                        curTag    <= fifoHead;
                        issueIdx  <= '0;
                        romRdEn   <= 1'b1;
                        romRdAddr <= wordAddr(fifoHead, '0);
                        state     <= FETCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    if (issueIdx == LAST_WORD_IDX) begin
                        state <= DRAIN;
                    end else begin
                        issueIdx  <= nextIdx;
                        romRdEn   <= 1'b1;
                        romRdAddr <= wordAddr(curTag, nextIdx);
                    end
                end
                DRAIN: begin
                    rspTag   <= curTag;
                    rspLine  <= lineNext;
                    rspValid <= 1'b1;
                    state    <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_readyOut        = !fifoFull;
    assign bus.rsp_tagOut          = rspTag;
    assign bus.rsp_insLineOut      = rspLine;
    assign bus.rsp_insLineValidOut = rspValid;
    assign bus.rom_rdEnOut         = romRdEn;
    assign bus.rom_rdAddrOut       = romRdAddr;
    assign bus.busyOut             = (state != IDLE) || !fifoEmpty;
    assign bus.overflowErrOut      = overflowErr;

endmodule

// File: tb/tb_ifu_mem_rsp.sv
// Directed bench for ifu_mem_rsp. Cycle labels are the value of cyc during a
// clock period; inputs change and outputs are sampled 1 ns after a rising edge.
module tb_ifu_mem_rsp;
    import ifu_pkg::*;

    logic Clock = 1'b0;
    logic Rst   = 1'b0;
    always #5 Clock = ~Clock;

    ifu_mem_rsp_if bus();

    ifu_mem_rsp dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge Clock) cyc++;

    int checks = 0;
    int errors = 0;
    bit romMode = 1'b0;

    // ROM: mode 0 returns DEADBEEF, mode 1 returns addr ^ 5A5A0000; junk when idle.
    always @(posedge Clock) begin
        if (bus.rom_rdEnOut)
            bus.rom_rdDataIn <= romMode ? (bus.rom_rdAddrOut ^ 32'h5A5A0000) : 32'hDEADBEEF;
        else
            bus.rom_rdDataIn <= 32'hBAD0BAD0;
    end

    int                    rdCyc[$];
    logic [ADDR_WIDTH-1:0] rdAddr[$];
    int                    pCyc[$];
    logic [TAG_WIDTH-1:0]  pTag[$];
    logic [LINE_WIDTH-1:0] pLine[$];

    always @(negedge Clock) begin
        if (bus.rom_rdEnOut) begin
            rdCyc.push_back(cyc);
            rdAddr.push_back(bus.rom_rdAddrOut);
        end
        if (bus.rsp_insLineValidOut) begin
            pCyc.push_back(cyc);
            pTag.push_back(bus.rsp_tagOut);
            pLine.push_back(bus.rsp_insLineOut);
        end
    end

    logic [63:0] expLine3 [5] = '{64'h5A5A0084_5A5A0080, 64'h5A5A008C_5A5A0088,
                                  64'h5A5A0094_5A5A0090, 64'h5A5A009C_5A5A0098,
                                  64'h5A5A00A4_5A5A00A0};
    logic [31:0] expAddr1 [2] = '{32'h12345678, 32'h1234567C};

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clearLogs();
        rdCyc.delete(); rdAddr.delete();
        pCyc.delete(); pTag.delete(); pLine.delete();
    endtask

    task automatic pushOne(input logic [TAG_WIDTH-1:0] tag, output int tCyc);
        bus.req_tagIn      = tag;
        bus.req_tagValidIn = 1'b1;
        tCyc = cyc;
        tick();
        bus.req_tagValidIn = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (bus.busyOut && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(bus.busyOut), 64'd0);
    endtask

    task automatic chkZeroOutputs(input string pfx);
        chk({pfx, "_rspValid"}, 64'(bus.rsp_insLineValidOut), 64'd0);
        chk({pfx, "_rspTag"},   64'(bus.rsp_tagOut), 64'd0);
        chk({pfx, "_rspLine"},  bus.rsp_insLineOut, 64'd0);
        chk({pfx, "_romEn"},    64'(bus.rom_rdEnOut), 64'd0);
        chk({pfx, "_romAddr"},  64'(bus.rom_rdAddrOut), 64'd0);
        chk({pfx, "_busy"},     64'(bus.busyOut), 64'd0);
        chk({pfx, "_ovf"},      64'(bus.overflowErrOut), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.req_tagIn      = '0;
        bus.req_tagValidIn = 1'b0;

        // Reset
        Rst = 1'b0;
        repeat (3) tick();
        chkZeroOutputs("reset");
        Rst = 1'b1;
        tick();

        // Single request, latency and ROM addresses
        romMode = 1'b0;
        clearLogs();
        pushOne(29'h02468ACF, t);
        repeat (7) tick();
        chk("t1_reads", 64'(rdCyc.size()), 64'd2);
        for (int i = 0; i < rdCyc.size() && i < 2; i++) begin
            chk("t1_readCyc",  64'(rdCyc[i]), 64'(t + 2 + i));
            chk("t1_readAddr", 64'(rdAddr[i]), 64'(expAddr1[i]));
        end
        chk("t1_pulses", 64'(pCyc.size()), 64'd1);
        if (pCyc.size() > 0) begin
            chk("t1_pulseCyc", 64'(pCyc[0]), 64'(t + 5));
            chk("t1_pulseTag", 64'(pTag[0]), 64'h02468ACF);
            chk("t1_pulseLine", pLine[0], 64'hDEADBEEF_DEADBEEF);
        end
        chk("t1_holdValid", 64'(bus.rsp_insLineValidOut), 64'd0);
        chk("t1_holdTag",   64'(bus.rsp_tagOut), 64'h02468ACF);
        chk("t1_holdLine",  bus.rsp_insLineOut, 64'hDEADBEEF_DEADBEEF);

        // Cache holds its miss request; it drops it once the fill returns
        clearLogs();
        bus.req_tagIn      = 29'h02468ACF;
        bus.req_tagValidIn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rsp_insLineValidOut) bus.req_tagValidIn = 1'b0;
        end
        bus.req_tagValidIn = 1'b0;
        waitIdle(20);
        repeat (3) tick();
        chk("t2_reads",  64'(rdCyc.size()), 64'd2);
        chk("t2_pulses", 64'(pCyc.size()), 64'd1);
        chk("t2_ovf",    64'(bus.overflowErrOut), 64'd0);

        // Fill the queue, then overflow it
        romMode = 1'b1;
        clearLogs();
        t = cyc;
        for (int k = 0; k < 5; k++) begin
            bus.req_tagIn      = TAG_WIDTH'(32'h10 + k);
            bus.req_tagValidIn = 1'b1;
            tick();
        end
        chk("t3_readyFull", 64'(bus.req_readyOut), 64'd0);
        bus.req_tagIn = 29'h15;
        tick();
        bus.req_tagValidIn = 1'b0;
        chk("t3_ovf", 64'(bus.overflowErrOut), 64'd1);
        waitIdle(40);
        chk("t3_reads",  64'(rdCyc.size()), 64'd10);
        chk("t3_pulses", 64'(pCyc.size()), 64'd5);
        for (int k = 0; k < pCyc.size() && k < 5; k++) begin
            chk("t3_pulseCyc",  64'(pCyc[k]), 64'(t + 5 + 4 * k));
            chk("t3_pulseTag",  64'(pTag[k]), 64'(32'h10 + k));
            chk("t3_pulseLine", pLine[k], expLine3[k]);
        end

        // Reset during DRAIN abandons the fetch
        clearLogs();
        pushOne(29'h30, t);
        repeat (3) tick();
        Rst = 1'b0;
        tick();
        chkZeroOutputs("t4_afterRst");
        Rst = 1'b1;
        repeat (3) tick();
        chk("t4_noPulse", 64'(pCyc.size()), 64'd0);
        clearLogs();
        pushOne(29'h31, t);
        repeat (7) tick();
        chk("t4_pulses", 64'(pCyc.size()), 64'd1);
        if (pCyc.size() > 0) begin
            chk("t4_pulseCyc",  64'(pCyc[0]), 64'(t + 5));
            chk("t4_pulseTag",  64'(pTag[0]), 64'h31);
            chk("t4_pulseLine", pLine[0], 64'h5A5A018C_5A5A0188);
        end

        // Same tag during its RESP cycle is a duplicate; one cycle later it is not
        clearLogs();
        bus.req_tagIn      = 29'h20;
        bus.req_tagValidIn = 1'b1;
        t = cyc;
        tick();
        bus.req_tagValidIn = 1'b0;
        repeat (4) tick();
        chk("t5_pulseNow", 64'(bus.rsp_insLineValidOut), 64'd1);
        bus.req_tagValidIn = 1'b1;
        tick();
        tick();
        bus.req_tagValidIn = 1'b0;
        repeat (8) tick();
        chk("t5_reads",  64'(rdCyc.size()), 64'd4);
        chk("t5_pulses", 64'(pCyc.size()), 64'd2);
        if (pCyc.size() > 1) begin
            chk("t5_pulse0Cyc", 64'(pCyc[0]), 64'(t + 5));
            chk("t5_pulse1Cyc", 64'(pCyc[1]), 64'(t + 11));
            chk("t5_pulse1Tag", 64'(pTag[1]), 64'h20);
            chk("t5_pulse1Line", pLine[1], 64'h5A5A0104_5A5A0100);
        end
        chk("t5_ovf", 64'(bus.overflowErrOut), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_mem_rsp.md
Name: ifu_mem_rsp

Overview:
Memory-side responder for the IFU cache line-fill interface. It accepts miss tags from the cache's request port (mem_reqTag*) and fetches the line word-by-word from a word-wide instruction ROM port. It assembles the line and returns it on the cache's response port (mem_rsp*) as a one-cycle valid pulse. Requests are queued in a small tag FIFO, and duplicate tags from a cache that holds its request during a miss are suppressed.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 64, cache line width in bits
WORD_WIDTH, 32, ROM read-port width
OFFSET_WIDTH, 3, log2(LINE_WIDTH/8)
TAG_WIDTH, ADDR_WIDTH-OFFSET_WIDTH, line tag width
WORDS_PER_LINE, LINE_WIDTH/WORD_WIDTH, words per line; must be a power of 2, >=2
REQ_FIFO_DEPTH, 4, pending-tag queue depth, power of 2

Ports:
Clock  in  1  clock
Rst  in  1  reset, synchronous, active-low
req_tagIn  in  TAG_WIDTH  miss tag from cache
req_tagValidIn  in  1  tag valid
req_readyOut  out  1  FIFO not full
rsp_tagOut  out  TAG_WIDTH  tag of returned line
rsp_insLineOut  out  LINE_WIDTH  returned line
rsp_insLineValidOut  out  1  one-cycle response pulse
rom_rdEnOut  out  1  ROM word read strobe
rom_rdAddrOut  out  ADDR_WIDTH  ROM byte address, word aligned
rom_rdDataIn  in  WORD_WIDTH  ROM data, valid exactly 1 cycle after rom_rdEnOut
busyOut  out  1  state != IDLE or FIFO non-empty
overflowErrOut  out  1  sticky: non-duplicate request dropped while full

Behaviour:
- Reset (Rst==0 at posedge):
  - All outputs are 0. FIFO is empty. State is IDLE. Word counters are 0. overflowErrOut is cleared.
  - Any in-flight fetch is abandoned with no response pulse.
  - ROM data arriving in the cycle after reset is ignored.
- Accept rules:
  - req_readyOut = !full, computed from registered state only. A pop in the same cycle does not free a slot.
  - A request is accepted when req_tagValidIn is high, req_readyOut is high, and the tag is not a duplicate.
- Duplicate rule:
  - A tag is a duplicate if it matches any valid FIFO entry, or matches curTag while state != IDLE (including the RESP cycle).
  - Duplicates are dropped silently and never set overflowErrOut.
- Overflow: a non-duplicate valid request while full is dropped and sets overflowErrOut to 1 until reset.
- FSM states: IDLE, FETCH, DRAIN, RESP.
  - IDLE: if FIFO non-empty, pop head into curTag, then go to FETCH.
  - FETCH: issue one read per cycle: rom_rdEnOut=1, rom_rdAddrOut={curTag, issueIdx, 2'b00}. issueIdx counts 0..WORDS_PER_LINE-1. Go to DRAIN after the last issue.
  - DRAIN: capture the final word, then go to RESP.
  - RESP: rsp_insLineValidOut=1 for exactly this cycle. If the FIFO is non-empty, pop and go to FETCH; else go to IDLE.
- Capture: every cycle after a read strobe, rom_rdDataIn is written to line[capIdx*WORD_WIDTH +: WORD_WIDTH] (word 0 at LSBs) and capIdx increments.
- Response outputs:
  - rsp_tagOut and rsp_insLineOut are registered.
  - They hold their value after the pulse until the next response.
  - They are undefined-free: 0 until the first response.
- Latency: request accepted in cycle T with FIFO empty and IDLE gives rsp_insLineValidOut at T+3+WORDS_PER_LINE (T+5 by default).
- Back-to-back: consecutive pulses are WORDS_PER_LINE+2 cycles apart.
- Simultaneous push and pop on a non-full FIFO: both occur and count is unchanged.
- Pointer wrap: read and write pointers wrap modulo REQ_FIFO_DEPTH. An extra bit distinguishes full from empty.

Decomposition:
- ifu_pkg adds:
  - WORD_WIDTH, WORDS_PER_LINE, REQ_FIFO_DEPTH
  - t_mem_rsp_state enum {IDLE, FETCH, DRAIN, RESP}
  - localparam WORD_IDX_WIDTH = $clog2(WORDS_PER_LINE)
- One sub-module, ifu_req_fifo:
  - Tag FIFO with push, pop, full and empty.
  - Combinational matchOut: the input tag equals any valid entry.

Test Plan:
- Reset, then req_tag=0x02468ACF (addr 0x12345678) valid 1 cycle; ROM model returns 0xDEADBEEF at 0x12345678 and 0x1234567C.
  - Reads occur at T+2 and T+3 with those addresses.
  - Pulse at T+5 with tag 0x02468ACF and line 0xDEADBEEFDEADBEEF.
- Hold the same tag valid for 10 cycles (cache miss behaviour) -> exactly one ROM fetch pair, exactly one response pulse, overflowErrOut=0.
- Push 5 distinct tags 0x10..0x14 on consecutive cycles while ROM returns {tag,idx} patterns:
  - Tags 0x10..0x14 are all accepted: 0x10 is popped at T+1 before the FIFO fills, leaving 0x11..0x14 queued.
  - Then push distinct tag 0x15 while full: req_readyOut=0, 0x15 is dropped, overflowErrOut=1.
  - Tags 0x10..0x14 return in order, pulses 4 cycles apart.
- Assert Rst=0 during the DRAIN cycle of a fetch -> no pulse, all outputs 0 next cycle, busyOut=0. A new request then completes normally with latency 5.
- Push tag 0x20; when its pulse fires, push tag 0x20 again in the same cycle -> dropped as duplicate. Pushing 0x20 one cycle later -> accepted and fetched again.
